// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART Wishbone controller.
//   - 16550 register indices used by the controller
//   - controller FSM state encoding
//   - IIR interrupt codes that mean "RX data waiting"
//   - LSR bit index of THR-empty
//   - request record handed from the FSM to the bus engine
package uart_ctrl_pkg;

  localparam logic [4:0] RBR_THR = 5'd0;
  localparam logic [4:0] IER     = 5'd1;
  localparam logic [4:0] IIR_FCR = 5'd2;
  localparam logic [4:0] LCR     = 5'd3;
  localparam logic [4:0] LSR     = 5'd5;

  // IIR[3:1] codes: RX data available, character timeout
  localparam logic [2:0] IIR_RDA = 3'b010;
  localparam logic [2:0] IIR_CTI = 3'b110;

  localparam int LSR_THRE = 5;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_READY, ST_RX_IIR, ST_RX_RBR, ST_TX_LSR, ST_TX_THR
  } state_e;

  typedef struct packed {
    logic [4:0] addr;
    logic       we;
    logic [7:0] wdata;
  } xact_req_t;

  function automatic logic iir_is_rx(input logic [7:0] iir);
    return (iir[3:1] == IIR_RDA) || (iir[3:1] == IIR_CTI);
  endfunction

endpackage

// File: rtl/uart_wb_xact.sv
// Single Wishbone transaction engine.
//   start/addr/we/wdata : launch one byte access (ignored while a cycle is open)
//   done                : high in the ack cycle; rdata valid alongside it
//   timeout             : high in the last strobe cycle when no ack arrived
//   wb_*                : registered master pins, held until ack or timeout
// The byte sits in lane addr[1:0] both for writes and for read-back.
module uart_wb_xact
  import uart_ctrl_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        start,
  input  logic [4:0]  addr,
  input  logic        we,
  input  logic [7:0]  wdata,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  rdata,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i
);

  logic [7:0] cnt;
  logic       last;

  assign last    = (cnt == TIMEOUT - 8'd1);
  assign done    = wb_stb_o & wb_ack_i;
  assign timeout = wb_stb_o & ~wb_ack_i & last;
  assign rdata   = wb_dat_i[{wb_addr_o[1:0], 3'b000} +: 8];

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_addr_o <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      cnt       <= '0;
    end else if (wb_stb_o) begin
      if (wb_ack_i || last) begin
        wb_cyc_o  <= 1'b0;
        wb_stb_o  <= 1'b0;
        wb_we_o   <= 1'b0;
        wb_addr_o <= '0;
        wb_dat_o  <= '0;
        wb_sel_o  <= '0;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end else if (start) begin
      wb_cyc_o  <= 1'b1;
      wb_stb_o  <= 1'b1;
      wb_we_o   <= we;
      wb_addr_o <= addr;
      wb_sel_o  <= 4'b0001 << addr[1:0];
      wb_dat_o  <= we ? (32'(wdata) << {addr[1:0], 3'b000}) : 32'h0;
      cnt       <= '0;
    end
  end

endmodule

// File: rtl/uart_wb_ctrl.sv
// Wishbone master that brings up a 16550-style UART and then services it.
//   init_start_i/init_done_o/err_o : init sequence control and sticky timeout
//   tx_valid_i/tx_data_i/tx_ready_o: one-deep TX byte latch
//   rx_valid_o/rx_data_o           : one-cycle pulse per received byte
//   int_i                          : UART interrupt line
//   wb_*                           : master side of the UART slave port
// Every bus-issuing state launches one access, then waits for done/timeout.
module uart_wb_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter logic [15:0] DIVISOR = 16'd27,
  parameter logic [7:0]  LCR_VAL = 8'h03,
  parameter logic [7:0]  FCR_VAL = 8'hC7,
  parameter logic [7:0]  IER_VAL = 8'h01,
  parameter logic [7:0]  TIMEOUT = 8'd255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        init_start_i,
  output logic        init_done_o,
  output logic        err_o,
  input  logic        tx_valid_i,
  input  logic [7:0]  tx_data_i,
  output logic        tx_ready_o,
  output logic        rx_valid_o,
  output logic [7:0]  rx_data_o,
  input  logic        int_i,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i
);

  state_e     state;
  logic [2:0] step;
  logic       busy, x_start, x_done, x_tout, tx_full, last_rx, bus_state;
  logic [7:0] tx_byte, x_rdata;
  xact_req_t  req, cur_req;

  function automatic xact_req_t init_req(input logic [2:0] s);
    case (s)
      3'd0:    return '{addr: LCR,     we: 1'b1, wdata: LCR_VAL | 8'h80};
      3'd1:    return '{addr: RBR_THR, we: 1'b1, wdata: DIVISOR[7:0]};
      3'd2:    return '{addr: IER,     we: 1'b1, wdata: DIVISOR[15:8]};
      3'd3:    return '{addr: LCR,     we: 1'b1, wdata: LCR_VAL};
      3'd4:    return '{addr: IIR_FCR, we: 1'b1, wdata: FCR_VAL};
      default: return '{addr: IER,     we: 1'b1, wdata: IER_VAL};
    endcase
  endfunction

  always_comb begin
    cur_req = '{addr: RBR_THR, we: 1'b0, wdata: 8'h00};
    case (state)
      ST_INIT:   cur_req = init_req(step);
      ST_RX_IIR: cur_req.addr = IIR_FCR;
      ST_TX_LSR: cur_req.addr = LSR;
      ST_TX_THR: cur_req = '{addr: RBR_THR, we: 1'b1, wdata: tx_byte};
      default:   ;
    endcase
  end

  assign bus_state  = (state != ST_IDLE) && (state != ST_READY);
  assign tx_ready_o = (state == ST_READY) && !tx_full;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state       <= ST_IDLE;
      step        <= '0;
      busy        <= 1'b0;
      x_start     <= 1'b0;
      req         <= '0;
      tx_full     <= 1'b0;
      tx_byte     <= '0;
      last_rx     <= 1'b0;
      init_done_o <= 1'b0;
      err_o       <= 1'b0;
      rx_valid_o  <= 1'b0;
      rx_data_o   <= '0;
    end else begin
      x_start    <= 1'b0;
      rx_valid_o <= 1'b0;
      if (tx_ready_o && tx_valid_i) begin
        tx_full <= 1'b1;
        tx_byte <= tx_data_i;
      end
      if (busy && x_tout) begin
        busy        <= 1'b0;
        err_o       <= 1'b1;
        init_done_o <= 1'b0;
        state       <= ST_IDLE;
      end else if (bus_state && !busy) begin
        x_start <= 1'b1;
        busy    <= 1'b1;
        req     <= cur_req;
      end else begin
        case (state)
          ST_IDLE: if (init_start_i) begin
            err_o <= 1'b0;
            step  <= '0;
            state <= ST_INIT;
          end
          ST_INIT: if (x_done) begin
            busy <= 1'b0;
            if (step == 3'd5) begin
              init_done_o <= 1'b1;
              state       <= ST_READY;
            end else begin
              step <= step + 3'd1;
            end
          end
          ST_READY: begin
            if (init_start_i) begin
              init_done_o <= 1'b0;
              step        <= '0;
              state       <= ST_INIT;
            // RX wins unless a TX byte waits and RX was served last
            end else if (int_i && (!tx_full || !last_rx)) begin
              last_rx <= 1'b1;
              state   <= ST_RX_IIR;
            end else if (tx_full) begin
              last_rx <= 1'b0;
              state   <= ST_TX_LSR;
            end
          end
          ST_RX_IIR: if (x_done) begin
            busy  <= 1'b0;
            state <= iir_is_rx(x_rdata) ? ST_RX_RBR : ST_READY;
          end
          ST_RX_RBR: if (x_done) begin
            busy       <= 1'b0;
            rx_valid_o <= 1'b1;
            rx_data_o  <= x_rdata;
            state      <= ST_READY;
          end
          ST_TX_LSR: if (x_done) begin
            busy  <= 1'b0;
            state <= x_rdata[LSR_THRE] ? ST_TX_THR : ST_READY;
          end
          ST_TX_THR: if (x_done) begin
            busy    <= 1'b0;
            tx_full <= 1'b0;
            state   <= ST_READY;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  uart_wb_xact #(.TIMEOUT(TIMEOUT)) u_xact (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n_i (wb_rst_n_i),
    .start      (x_start),
    .addr       (req.addr),
    .we         (req.we),
    .wdata      (req.wdata),
    .done       (x_done),
    .timeout    (x_tout),
    .rdata      (x_rdata),
    .wb_addr_o  (wb_addr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_o   (wb_sel_o),
    .wb_we_o    (wb_we_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_ack_i   (wb_ack_i)
  );

endmodule
